seq_alu: RTL and testbench

Sequential, parametrised successor of the team's 4-bit combinational ALU. It keeps the same eight operations and the same 3-bit select encoding, generalised to WIDTH bits, and adds a valid/ready handshake on both sides, registered results with status flags, and a multi-cycle variable-amount arithmetic shift right. It sits between an operand-issuing controller and a result consumer that may apply backpressure.

---
 rtl/seq_alu_pkg.sv | 21 ++
 rtl/seq_alu_core.sv | 57 +++++
 rtl/seq_alu.sv | 129 ++++++++++++
 tb/tb_seq_alu.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and controller states.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_INC = 3'b000,
    OP_ASR = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_DEC = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_core.sv
// Combinational datapath for every single-cycle operation; ASR is handled by the top.
module alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   result,
  output logic             flag_v
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH:0] sum_ab;
  logic [WIDTH:0] dif_ab;
  logic [WIDTH:0] inc_a;
  logic [WIDTH:0] dec_a;

  // Zero-extended arithmetic puts carry/borrow naturally into bit WIDTH.
  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign dif_ab = {1'b0, a} - {1'b0, b};
  assign inc_a  = {1'b0, a} + {1'b0, ONE};
  assign dec_a  = {1'b0, a} - {1'b0, ONE};

  always_comb begin
    result = '0;
    flag_v = 1'b0;
    case (op_t'(op))
      OP_INC: begin
        result = inc_a;
        flag_v = ~a[WIDTH-1] & inc_a[WIDTH-1];
      end
      OP_ADD: begin
        result = sum_ab;
        flag_v = (a[WIDTH-1] == b[WIDTH-1]) & (sum_ab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = dif_ab;
        flag_v = (a[WIDTH-1] != b[WIDTH-1]) & (dif_ab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DEC: begin
        result = dec_a;
        flag_v = a[WIDTH-1] & ~dec_a[WIDTH-1];
      end
      OP_AND: result = {1'b0, a & b};
      OP_OR:  result = {1'b0, a | b};
      OP_XOR: result = {1'b0, a ^ b};
      default: begin
        result = '0;
        flag_v = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready request and result ports, registered result and flags,
// and a one-bit-per-cycle arithmetic shift right.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH:0]   result_reg;
  logic             flag_z_reg;
  logic             flag_n_reg;
  logic             flag_v_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [WIDTH:0]   core_result;
  logic             core_v;
  logic [WIDTH-1:0] shift_next;
  logic [SHW-1:0]   amt;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (core_result),
    .flag_v (core_v)
  );

  assign shift_next = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
  assign amt        = b[SHW-1:0];
  assign accept     = in_valid & in_ready_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      flag_z_reg    <= 1'b0;
      flag_n_reg    <= 1'b0;
      flag_v_reg    <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            in_ready_reg <= 1'b0;
            if (op_t'(op) == OP_ASR) begin
              shift_reg <= a;
              cnt_reg   <= amt;
              if (amt == '0) begin
                result_reg    <= {1'b0, a};
                flag_z_reg    <= (a == '0);
                flag_n_reg    <= a[WIDTH-1];
                flag_v_reg    <= 1'b0;
                out_valid_reg <= 1'b1;
                state_reg     <= DONE;
              end else begin
                state_reg <= SHIFT;
              end
            end else begin
              result_reg    <= core_result;
              flag_z_reg    <= (core_result[WIDTH-1:0] == '0);
              flag_n_reg    <= core_result[WIDTH-1];
              flag_v_reg    <= core_v;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg - CNT_ONE;
          // Last shift: publish the value being shifted in this very edge.
          if (cnt_reg == CNT_ONE) begin
            result_reg    <= {1'b0, shift_next};
            flag_z_reg    <= (shift_next == '0);
            flag_n_reg    <= shift_next[WIDTH-1];
            flag_v_reg    <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flag_z    = flag_z_reg;
  assign flag_n    = flag_n_reg;
  assign flag_v    = flag_v_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=4 with hand-computed expectations.
module tb_seq_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] result;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;

  int n_cmp;
  int n_bad;

  seq_alu #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with out_ready=1 and check latency, result, flags and return to idle.
  task automatic do_req(input string tag, input logic [2:0] o, input logic [3:0] va,
                        input logic [3:0] vb, input logic [4:0] er, input logic ez,
                        input logic en, input logic ev, input int elat);
    int lat;
    out_ready = 1'b1;
    op = o; a = va; b = vb; in_valid = 1'b1;
    check({tag, ".in_ready_pre"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a = 4'h0; b = 4'h0; op = 3'b000;
    check({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".result"}, {27'd0, result}, {27'd0, er});
    check({tag, ".flags"}, {29'd0, flag_z, flag_n, flag_v}, {29'd0, ez, en, ev});
    $display("req %s op=%b a=%b b=%b -> result=%b z=%b n=%b v=%b lat=%0d",
             tag, o, va, vb, result, flag_z, flag_n, flag_v, lat);
    tick();
    check({tag, ".idle_ready"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'b000; a = 4'h0; b = 4'h0;
    #12;
    check("reset.outputs", {25'd0, in_ready, out_valid, result},
          {25'd0, 1'b1, 1'b0, 5'd0});
    check("reset.flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_req("inc_wrap", 3'b000, 4'b1111, 4'b0000, 5'b1_0000, 1'b1, 1'b0, 1'b0, 1);
    do_req("add_ovf",  3'b010, 4'b0111, 4'b0001, 5'b0_1000, 1'b0, 1'b1, 1'b1, 1);
    do_req("add_cry",  3'b010, 4'b1111, 4'b1010, 5'b1_1001, 1'b0, 1'b1, 1'b0, 1);
    do_req("sub_brw",  3'b011, 4'b0011, 4'b0101, 5'b1_1110, 1'b0, 1'b1, 1'b0, 1);
    do_req("sub_b0",   3'b011, 4'b0101, 4'b0000, 5'b0_0101, 1'b0, 1'b0, 1'b0, 1);
    do_req("dec_zero", 3'b100, 4'b0000, 4'b0000, 5'b1_1111, 1'b0, 1'b1, 1'b0, 1);
    do_req("dec_ovf",  3'b100, 4'b1000, 4'b0000, 5'b0_0111, 1'b0, 1'b0, 1'b1, 1);
    do_req("and",      3'b101, 4'b1100, 4'b1010, 5'b0_1000, 1'b0, 1'b1, 1'b0, 1);
    do_req("or",       3'b110, 4'b0100, 4'b0010, 5'b0_0110, 1'b0, 1'b0, 1'b0, 1);
    do_req("asr3",     3'b001, 4'b1000, 4'b0011, 5'b0_1111, 1'b0, 1'b1, 1'b0, 4);
    do_req("asr0",     3'b001, 4'b1000, 4'b0000, 5'b0_1000, 1'b0, 1'b1, 1'b0, 1);
    do_req("asr_hib",  3'b001, 4'b0110, 4'b1101, 5'b0_0011, 1'b0, 1'b0, 1'b0, 2);

    // Backpressure: result held while out_ready is low, new requests refused.
    out_ready = 1'b0;
    op = 3'b111; a = 4'b1100; b = 4'b1010; in_valid = 1'b1;
    tick();
    op = 3'b010; a = 4'b0001; b = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      check("bp.held", {24'd0, in_ready, out_valid, flag_z, result, flag_v},
            {24'd0, 1'b0, 1'b1, 1'b0, 5'b0_0110, 1'b0});
      tick();
    end
    $display("req bp op=111 a=1100 b=1010 -> result=%b held", result);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp.handoff", {30'd0, in_ready, out_valid}, 32'b10);
    tick();
    check("bp.no_accept", {30'd0, in_ready, out_valid}, 32'b10);

    // Leave nonzero result/flags behind, then reset in the middle of a shift.
    do_req("add_pre",  3'b010, 4'b0111, 4'b0001, 5'b0_1000, 1'b0, 1'b1, 1'b1, 1);
    op = 3'b001; a = 4'b1000; b = 4'b0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    check("rst_mid.outputs", {25'd0, in_ready, out_valid, result},
          {25'd0, 1'b1, 1'b0, 5'd0});
    check("rst_mid.flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid.ready", {30'd0, in_ready, out_valid}, 32'b10);
    $display("req rst_mid asr n=3 aborted after one shift");
    tick();
    do_req("add_post", 3'b010, 4'b0010, 4'b0011, 5'b0_0101, 1'b0, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
